fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter for the synchronous FIFO (FIFO_WIDTH data path).

---
 rtl/fifo_wr_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add saturating wr_count / ovf_count outputs.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic                          busy,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                          fifo_overflow,
    output logic [31:0]                   wr_count,
    output logic [15:0]                   ovf_count
`else
    input  logic                          fifo_overflow
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_d;

    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        rr_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [RW-1:0]           retry_cnt;
    logic [RW-1:0]           retry_d;

    logic [NUM_REQ-1:0]      gnt_d;
    logic [NUM_REQ-1:0]      done_d;
    logic                    err_d;
    logic                    busy_d;
    logic                    wr_en_d;
    logic [FIFO_WIDTH-1:0]   data_d;

    logic                    pick_hit;
    logic [IDX_W-1:0]        pick_idx;
    logic [FIFO_WIDTH-1:0]   pick_data;
    logic                    retry_at_max;

    // The outcome is decided by wr_ack alone; anything else is an overflow.
    logic                    unused_ovf;
    assign unused_ovf = fifo_overflow;

    assign retry_at_max = (retry_cnt == RW'(MAX_RETRY));

    // Round-robin scan starting just after the last winner.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_hit && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_hit = 1'b1;
                pick_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        pick_data = req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (pick_hit && !fifo_full) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fifo_wr_ack || retry_at_max) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_d   = gnt;
        done_d  = '0;
        err_d   = 1'b0;
        wr_en_d = 1'b0;
        data_d  = fifo_data_in;
        idx_d   = idx_q;
        rr_d    = rr_ptr;
        retry_d = retry_cnt;
        busy_d  = (state_d != IDLE);
        unique case (state)
            IDLE: begin
                if (pick_hit && !fifo_full) begin
                    idx_d   = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    wr_en_d = 1'b1;
                    data_d  = pick_data;
                    retry_d = '0;
                end
            end
            ISSUE: begin
                wr_en_d = 1'b0;
            end
            WAIT: begin
                if (fifo_wr_ack || retry_at_max) begin
                    done_d  = NUM_REQ'(1) << idx_q;
                    err_d   = !fifo_wr_ack;
                    gnt_d   = '0;
                    rr_d    = idx_q;
                    retry_d = '0;
                end else begin
                    retry_d = retry_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Output and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            done         <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            idx_q        <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            retry_cnt    <= '0;
        end else begin
            gnt          <= gnt_d;
            done         <= done_d;
            err          <= err_d;
            busy         <= busy_d;
            fifo_wr_en   <= wr_en_d;
            fifo_data_in <= data_d;
            idx_q        <= idx_d;
            rr_ptr       <= rr_d;
            retry_cnt    <= retry_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturating counters of acked writes and failed attempts.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count  <= '0;
            ovf_count <= '0;
        end else if (state == WAIT) begin
            if (fifo_wr_ack) begin
                if (wr_count != '1) begin
                    wr_count <= wr_count + 32'd1;
                end
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter.
// A responder models the FIFO's registered wr_ack / overflow.
module tb_fifo_wr_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [W-1:0] data;
        logic       err;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]    wr_count;
    logic [15:0]    ovf_count;
`endif

    int             n_cmp;
    int             n_err;
    int             ovf_left;
    logic [W-1:0]   dat [N];
    exp_t           exp_q [$];

    fifo_wr_arbiter #(
        .FIFO_WIDTH (W),
        .NUM_REQ    (N),
        .MAX_RETRY  (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
`ifdef FIFO_WR_ARB_STATS_EN
        .fifo_overflow (fifo_overflow),
        .wr_count      (wr_count),
        .ovf_count     (ovf_count)
`else
        .fifo_overflow (fifo_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO responder: one-cycle registered ack or overflow per write.
    initial begin
        logic seen;
        fifo_wr_ack   = 1'b0;
        fifo_overflow = 1'b0;
        forever begin
            @(posedge clk);
            seen = (fifo_wr_en === 1'b1);
            #1;
            if (seen && ovf_left > 0) begin
                fifo_wr_ack   = 1'b0;
                fifo_overflow = 1'b1;
                ovf_left--;
            end else if (seen) begin
                fifo_wr_ack   = 1'b1;
                fifo_overflow = 1'b0;
            end else begin
                fifo_wr_ack   = 1'b0;
                fifo_overflow = 1'b0;
            end
        end
    end

    task automatic set_data(input logic [W-1:0] salt);
        for (int i = 0; i < N; i++) begin
            dat[i] = salt ^ W'(16'h1111 * (i + 1));
            req_data[i*W +: W] = dat[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        ovf_left  = 0;
        set_data(16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0) begin
            n_err++; $display("FAIL reset_gnt: got %b want 0", gnt);
        end
        n_cmp++;
        if (done !== '0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", done);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL reset_err: got %b want 0", err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin
            n_err++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en);
        end
        n_cmp++;
        if (fifo_data_in !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", fifo_data_in);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        int   cyc = 0;
        int   pulses = 0;
        bit   fin = 0;
        set_data(16'h0A0A);
        req = 4'b0001;
        exp_q.push_back('{0, dat[0], 1'b0});
        while (!fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (fifo_wr_en === 1'b1) begin
                pulses++;
                n_cmp++;
                if (gnt !== N'(1) << exp_q[0].idx || fifo_data_in !== exp_q[0].data) begin
                    n_err++;
                    $display("FAIL single_issue: got gnt=%b data=%h want gnt=%b data=%h",
                             gnt, fifo_data_in, N'(1) << exp_q[0].idx, exp_q[0].data);
                end
            end
            if (done !== '0) begin
                fin = 1;
                req = '0;
                e = exp_q.pop_front();
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== e.err) begin
                    n_err++;
                    $display("FAIL single_done: got done=%b err=%b want done=%b err=%b",
                             done, err, N'(1) << e.idx, e.err);
                end
                n_cmp++;
                if (cyc != 3) begin
                    n_err++; $display("FAIL single_latency: got %0d want 3", cyc);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++; $display("FAIL single_timeout: got no done want done");
            exp_q.delete();
            req = '0;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++; $display("FAIL single_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   cyc = 0;
        do_reset();
        set_data(16'h5A00);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{k % N, dat[k % N], 1'b0});
        end
        req = 4'b1111;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (fifo_wr_en === 1'b1) begin
                n_cmp++;
                if (gnt !== N'(1) << exp_q[0].idx || fifo_data_in !== exp_q[0].data) begin
                    n_err++;
                    $display("FAIL rr_issue: got gnt=%b data=%h want gnt=%b data=%h",
                             gnt, fifo_data_in, N'(1) << exp_q[0].idx, exp_q[0].data);
                end
            end
            if (done !== '0) begin
                e = exp_q.pop_front();
                if (exp_q.size() == 0) req = '0;
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_done: got done=%b err=%b want done=%b err=0",
                             done, err, N'(1) << e.idx);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
            req = '0;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_err++; $display("FAIL rr_idle: got busy=%b gnt=%b want 0/0", busy, gnt);
        end
    endtask

    task automatic test_full_stall();
        exp_t e;
        int   cyc = 0;
        int   bad = 0;
        bit   fin = 0;
        set_data(16'h3C3C);
        fifo_full = 1'b1;
        req = 4'b0010;
        exp_q.push_back('{1, dat[1], 1'b0});
        repeat (4) begin
            @(negedge clk);
            if (fifo_wr_en !== 1'b0 || gnt !== '0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL full_stall: got %0d active cycles want 0", bad);
        end
        fifo_full = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_wr_en !== 1'b1 || gnt !== 4'b0010 || fifo_data_in !== exp_q[0].data) begin
            n_err++;
            $display("FAIL full_release: got wr_en=%b gnt=%b data=%h want 1/0010/%h",
                     fifo_wr_en, gnt, fifo_data_in, exp_q[0].data);
        end
        while (!fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done !== '0) begin
                fin = 1;
                req = '0;
                e = exp_q.pop_front();
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== e.err) begin
                    n_err++;
                    $display("FAIL full_done: got done=%b err=%b want done=%b err=%b",
                             done, err, N'(1) << e.idx, e.err);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++; $display("FAIL full_timeout: got no done want done");
            exp_q.delete();
            req = '0;
        end
    endtask

    task automatic test_overflow_abandon();
        exp_t e;
        int   cyc = 0;
        int   pulses = 0;
        bit   fin = 0;
        do_reset();
        set_data(16'h7E01);
        ovf_left = 100;
        req = 4'b0100;
        exp_q.push_back('{2, dat[2], 1'b1});
        while (!fin && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (fifo_wr_en === 1'b1) begin
                pulses++;
                n_cmp++;
                if (gnt !== 4'b0100 || fifo_data_in !== exp_q[0].data) begin
                    n_err++;
                    $display("FAIL abandon_issue: got gnt=%b data=%h want 0100/%h",
                             gnt, fifo_data_in, exp_q[0].data);
                end
            end
            if (done !== '0) begin
                fin = 1;
                req = '0;
                ovf_left = 0;
                e = exp_q.pop_front();
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== e.err) begin
                    n_err++;
                    $display("FAIL abandon_done: got done=%b err=%b want done=%b err=%b",
                             done, err, N'(1) << e.idx, e.err);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++; $display("FAIL abandon_timeout: got no done want done");
            exp_q.delete();
            req = '0;
            ovf_left = 0;
        end
        n_cmp++;
        if (pulses != 4) begin
            n_err++; $display("FAIL abandon_pulses: got %0d want 4", pulses);
        end
`ifdef FIFO_WR_ARB_STATS_EN
        n_cmp++;
        if (ovf_count !== 16'd4 || wr_count !== 32'd0) begin
            n_err++;
            $display("FAIL abandon_stats: got ovf=%0d wr=%0d want 4/0", ovf_count, wr_count);
        end
`endif
    endtask

    task automatic test_retry_ok();
        exp_t e;
        int   cyc = 0;
        int   pulses = 0;
        bit   fin = 0;
        set_data(16'hC0DE);
        ovf_left = 1;
        req = 4'b1000;
        exp_q.push_back('{3, dat[3], 1'b0});
        while (!fin && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (fifo_wr_en === 1'b1) begin
                pulses++;
                n_cmp++;
                if (gnt !== 4'b1000 || fifo_data_in !== exp_q[0].data) begin
                    n_err++;
                    $display("FAIL retry_issue: got gnt=%b data=%h want 1000/%h",
                             gnt, fifo_data_in, exp_q[0].data);
                end
            end
            if (done !== '0) begin
                fin = 1;
                req = '0;
                e = exp_q.pop_front();
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== e.err) begin
                    n_err++;
                    $display("FAIL retry_done: got done=%b err=%b want done=%b err=%b",
                             done, err, N'(1) << e.idx, e.err);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++; $display("FAIL retry_timeout: got no done want done");
            exp_q.delete();
            req = '0;
        end
        n_cmp++;
        if (pulses != 2) begin
            n_err++; $display("FAIL retry_pulses: got %0d want 2", pulses);
        end
`ifdef FIFO_WR_ARB_STATS_EN
        n_cmp++;
        if (ovf_count !== 16'd5 || wr_count !== 32'd1) begin
            n_err++;
            $display("FAIL retry_stats: got ovf=%0d wr=%0d want 5/1", ovf_count, wr_count);
        end
`endif
        ovf_left = 0;
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        int   cyc = 0;
        int   bad = 0;
        bit   fin = 0;
        set_data(16'h9119);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || fifo_wr_en !== 1'b0 || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL rstwait_pre: got busy=%b wr_en=%b gnt=%b want 1/0/0001",
                     busy, fifo_wr_en, gnt);
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || busy !== 1'b0 ||
            fifo_wr_en !== 1'b0 || fifo_data_in !== '0) begin
            n_err++;
            $display("FAIL rstwait_outputs: got gnt=%b done=%b err=%b busy=%b wr_en=%b data=%h want all 0",
                     gnt, done, err, busy, fifo_wr_en, fifo_data_in);
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== '0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rstwait_quiet: got %0d active cycles want 0", bad);
        end
        req = 4'b1000;
        exp_q.push_back('{3, dat[3], 1'b0});
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b1000 || fifo_wr_en !== 1'b1 || fifo_data_in !== exp_q[0].data) begin
            n_err++;
            $display("FAIL rstwait_grant: got gnt=%b wr_en=%b data=%h want 1000/1/%h",
                     gnt, fifo_wr_en, fifo_data_in, exp_q[0].data);
        end
        while (!fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done !== '0) begin
                fin = 1;
                req = '0;
                e = exp_q.pop_front();
                n_cmp++;
                if (done !== N'(1) << e.idx || err !== e.err) begin
                    n_err++;
                    $display("FAIL rstwait_done: got done=%b err=%b want done=%b err=%b",
                             done, err, N'(1) << e.idx, e.err);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++; $display("FAIL rstwait_timeout: got no done want done");
            exp_q.delete();
            req = '0;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        ovf_left = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_overflow_abandon();
        test_retry_ok();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
